// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: PC request, byte-wide instruction memory bus
// and the IF/ID valid/ready handshake. master = fetch stage side.
interface if_fetch_if;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        stall_req_o;
    logic        flush_i;
    logic [31:0] mem_addr_o;
    logic        mem_rd_o;
    logic [7:0]  mem_din_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        id_ready_i;

    modport master (
        input  pc_i, ce_i, flush_i, mem_din_i, id_ready_i,
        output stall_req_o, mem_addr_o, mem_rd_o,
        output inst_o, inst_pc_o, inst_valid_o
    );

    modport slave (
        output pc_i, ce_i, flush_i, mem_din_i, id_ready_i,
        input  stall_req_o, mem_addr_o, mem_rd_o,
        input  inst_o, inst_pc_o, inst_valid_o
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: reads a 32-bit word as four pipelined byte
// reads (little-endian) and hands it to decode over valid/ready.
// Ports: clk, rst (sync, active-high), bus (if_fetch_if.master):
//   pc_i/ce_i/stall_req_o  - PC request and hold-back to PC register
//   flush_i                - abort in-flight fetch, drop pending word
//   mem_addr_o/mem_rd_o/mem_din_i - byte memory, 1-cycle read latency
//   inst_o/inst_pc_o/inst_valid_o/id_ready_i - IF/ID handshake
// Optional: define ICACHE_EN for a direct-mapped one-word-per-line
// cache of ICACHE_LINES entries (hits complete at the accept edge).
module if_fetch #(
    parameter int unsigned ICACHE_LINES = 64
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_if.master bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] S1   = 3'd1;
    localparam logic [2:0] S2   = 3'd2;
    localparam logic [2:0] S3   = 3'd3;
    localparam logic [2:0] S4   = 3'd4;
    localparam logic [2:0] S5   = 3'd5;

    logic [2:0]  state;
    logic [31:0] fetch_pc;
    logic [7:0]  b0, b1, b2;
    logic        slot_free;
    logic        accept;
    logic        hit;
    logic [31:0] hit_data;
    logic [31:0] word;

    assign slot_free = !bus.inst_valid_o || bus.id_ready_i;
    assign accept    = (state == IDLE) && bus.ce_i && !bus.flush_i
                       && slot_free;
    assign bus.stall_req_o = (state != IDLE)
                             || (bus.inst_valid_o && !bus.id_ready_i);
    assign word = {bus.mem_din_i, b2, b1, b0};

`ifdef ICACHE_EN
    localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
    // Tag keeps pc[1:0] too so unaligned PCs never alias aligned ones.
    localparam int unsigned TAG_W = 32 - IDX_W;

    logic [31:0]             c_data [ICACHE_LINES];
    logic [TAG_W-1:0]        c_tag  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] c_valid;
    logic [IDX_W-1:0]        req_idx, fill_idx;
    logic [TAG_W-1:0]        req_tag, fill_tag;

    assign req_idx  = bus.pc_i[2+IDX_W-1:2];
    assign req_tag  = {bus.pc_i[31:2+IDX_W], bus.pc_i[1:0]};
    assign fill_idx = fetch_pc[2+IDX_W-1:2];
    assign fill_tag = {fetch_pc[31:2+IDX_W], fetch_pc[1:0]};
    assign hit      = c_valid[req_idx] && (c_tag[req_idx] == req_tag);
    assign hit_data = c_data[req_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid <= '0;
            for (int i = 0; i < int'(ICACHE_LINES); i++) begin
                c_tag[i] <= '0;
            end
        end else if (!bus.flush_i && state == S5) begin
            c_valid[fill_idx] <= 1'b1;
            c_tag[fill_idx]   <= fill_tag;
            c_data[fill_idx]  <= word;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (ICACHE_LINES > 1);
    assign hit        = 1'b0;
    assign hit_data   = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            fetch_pc         <= '0;
            bus.mem_addr_o   <= '0;
            bus.mem_rd_o     <= 1'b0;
            bus.inst_o       <= '0;
            bus.inst_pc_o    <= '0;
            bus.inst_valid_o <= 1'b0;
            b0               <= '0;
            b1               <= '0;
            b2               <= '0;
        end else if (bus.flush_i) begin
            state            <= IDLE;
            bus.mem_rd_o     <= 1'b0;
            bus.inst_valid_o <= 1'b0;
            b0               <= '0;
            b1               <= '0;
            b2               <= '0;
        end else begin
            if (bus.inst_valid_o && bus.id_ready_i) begin
                bus.inst_valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            bus.inst_o       <= hit_data;
                            bus.inst_pc_o    <= bus.pc_i;
                            bus.inst_valid_o <= 1'b1;
                        end else begin
                            fetch_pc       <= bus.pc_i;
                            bus.mem_addr_o <= bus.pc_i;
                            bus.mem_rd_o   <= 1'b1;
                            state          <= S1;
                        end
                    end
                end
                S1: begin
                    bus.mem_addr_o <= fetch_pc + 32'd1;
                    state          <= S2;
                end
                S2: begin
                    b0             <= bus.mem_din_i;
                    bus.mem_addr_o <= fetch_pc + 32'd2;
                    state          <= S3;
                end
                S3: begin
                    b1             <= bus.mem_din_i;
                    bus.mem_addr_o <= fetch_pc + 32'd3;
                    state          <= S4;
                end
                S4: begin
                    b2           <= bus.mem_din_i;
                    bus.mem_rd_o <= 1'b0;
                    state        <= S5;
                end
                S5: begin
                    bus.inst_o       <= word;
                    bus.inst_pc_o    <= fetch_pc;
                    bus.inst_valid_o <= 1'b1;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: byte memory model, random PCs,
// backpressure, flush, address wrap and (with ICACHE_EN) cache hits.
module tb_if_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_if bus ();
    if_fetch #(.ICACHE_LINES(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  mem_ovr [logic [31:0]];
    logic [31:0] addr_q [$];
    int          got_lat;
    bit          stall_ok;
`ifdef ICACHE_EN
    logic [31:0] cmodel [int];
`endif

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2),
                mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
`ifdef ICACHE_EN
        int i;
        i = int'((pc >> 2) % 64);
        return cmodel.exists(i) && cmodel[i] == pc;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_done(input logic [31:0] pc);
`ifdef ICACHE_EN
        cmodel[int'((pc >> 2) % 64)] = pc;
`else
        if (pc === 32'hx) $display("note: unknown pc");
`endif
    endtask

    // Byte memory: data valid the cycle after the address is presented.
    always @(posedge clk) begin
        if (bus.mem_rd_o) bus.mem_din_i <= mem_byte(bus.mem_addr_o);
    end

    task automatic run_fetch(input logic [31:0] pc);
        @(negedge clk);
        bus.pc_i = pc;
        bus.ce_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ce_i = 1'b0;
        addr_q.delete();
        got_lat  = -1;
        stall_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (bus.mem_rd_o) addr_q.push_back(bus.mem_addr_o);
            if (bus.inst_valid_o) begin
                got_lat = k - 1;
                break;
            end
            if (!bus.stall_req_o) stall_ok = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.ce_i = 1'b1;
        bus.pc_i = 32'h10;
        bus.flush_i = 1'b0;
        bus.id_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (bus.inst_valid_o !== 1'b0)
            $display("FAIL reset_valid: got %b want 0", bus.inst_valid_o);
        else n_pass++;
        n_chk++;
        if (bus.mem_rd_o !== 1'b0)
            $display("FAIL reset_rd: got %b want 0", bus.mem_rd_o);
        else n_pass++;
        n_chk++;
        if (bus.mem_addr_o !== 32'h0)
            $display("FAIL reset_addr: got %h want 0", bus.mem_addr_o);
        else n_pass++;
        n_chk++;
        if (bus.stall_req_o !== 1'b0)
            $display("FAIL reset_stall: got %b want 0", bus.stall_req_o);
        else n_pass++;
        bus.ce_i = 1'b0;
        rst = 1'b0;
`ifdef ICACHE_EN
        cmodel.delete();
`endif
    endtask

    task automatic test_basic;
        bit h;
        int n;
        mem_ovr[32'h10] = 8'h13;
        mem_ovr[32'h11] = 8'h05;
        mem_ovr[32'h12] = 8'h10;
        mem_ovr[32'h13] = 8'h00;
        h = model_hit(32'h10);
        run_fetch(32'h10);
        n = h ? 0 : 4;
        n_chk++;
        if (addr_q.size() !== n)
            $display("FAIL basic_nreads: got %0d want %0d", addr_q.size(), n);
        else n_pass++;
        for (int i = 0; i < addr_q.size() && i < 4; i++) begin
            n_chk++;
            if (addr_q[i] !== 32'h10 + 32'(i))
                $display("FAIL basic_addr%0d: got %h want %h",
                         i, addr_q[i], 32'h10 + 32'(i));
            else n_pass++;
        end
        n_chk++;
        if (bus.inst_o !== 32'h00100513)
            $display("FAIL basic_inst: got %h want 00100513", bus.inst_o);
        else n_pass++;
        n_chk++;
        if (bus.inst_pc_o !== 32'h10)
            $display("FAIL basic_pc: got %h want 10", bus.inst_pc_o);
        else n_pass++;
        n_chk++;
        if (got_lat !== (h ? 0 : 5))
            $display("FAIL basic_lat: got %0d want %0d", got_lat, h ? 0 : 5);
        else n_pass++;
        n_chk++;
        if (stall_ok !== 1'b1)
            $display("FAIL basic_stall: got %b want 1", stall_ok);
        else n_pass++;
        model_done(32'h10);
    endtask

    task automatic test_backpressure;
        bit h;
        bit held;
        bit seen;
        h = model_hit(32'h10);
        run_fetch(32'h10);
        bus.id_ready_i = 1'b0;
        model_done(32'h10);
        n_chk++;
        if (got_lat !== (h ? 0 : 5))
            $display("FAIL bp_lat: got %0d want %0d", got_lat, h ? 0 : 5);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            held = bus.inst_o === 32'h00100513 && bus.inst_valid_o === 1'b1
                   && bus.stall_req_o === 1'b1 && bus.mem_rd_o === 1'b0;
            n_chk++;
            if (!held)
                $display("FAIL bp_hold%0d: got inst=%h v=%b st=%b rd=%b want 00100513 1 1 0",
                         c, bus.inst_o, bus.inst_valid_o,
                         bus.stall_req_o, bus.mem_rd_o);
            else n_pass++;
        end
        @(negedge clk);
        bus.id_ready_i = 1'b1;
        bus.pc_i = 32'h14;
        bus.ce_i = 1'b1;
        h = model_hit(32'h14);
        @(posedge clk);
        #1;
        bus.ce_i = 1'b0;
        n_chk++;
        if (!h && (bus.mem_rd_o !== 1'b1 || bus.mem_addr_o !== 32'h14
                   || bus.inst_valid_o !== 1'b0))
            $display("FAIL bp_accept: got rd=%b addr=%h v=%b want 1 14 0",
                     bus.mem_rd_o, bus.mem_addr_o, bus.inst_valid_o);
        else if (h && bus.inst_valid_o !== 1'b1)
            $display("FAIL bp_accept: got v=%b want 1", bus.inst_valid_o);
        else n_pass++;
        seen = bus.inst_valid_o;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = bus.inst_valid_o;
        end
        n_chk++;
        if (!seen || bus.inst_o !== model_word(32'h14)
            || bus.inst_pc_o !== 32'h14)
            $display("FAIL bp_next: got v=%b inst=%h pc=%h want 1 %h 14",
                     seen, bus.inst_o, bus.inst_pc_o, model_word(32'h14));
        else n_pass++;
        model_done(32'h14);
    endtask

    task automatic test_flush;
        bit seen;
        bit h;
        @(negedge clk);
        bus.pc_i = 32'h20;
        bus.ce_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ce_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        n_chk++;
        if (bus.mem_rd_o !== 1'b0 || bus.inst_valid_o !== 1'b0)
            $display("FAIL flush_abort: got rd=%b v=%b want 0 0",
                     bus.mem_rd_o, bus.inst_valid_o);
        else n_pass++;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.inst_valid_o) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0)
            $display("FAIL flush_novalid: got %b want 0", seen);
        else n_pass++;
        run_fetch(32'h40);
        n_chk++;
        if (bus.inst_o !== model_word(32'h40) || bus.inst_pc_o !== 32'h40)
            $display("FAIL flush_next: got %h@%h want %h@40",
                     bus.inst_o, bus.inst_pc_o, model_word(32'h40));
        else n_pass++;
        model_done(32'h40);
        h = model_hit(32'h20);
        run_fetch(32'h20);
        n_chk++;
        if (got_lat !== (h ? 0 : 5) || bus.inst_o !== model_word(32'h20))
            $display("FAIL flush_refetch: got lat=%0d inst=%h want %0d %h",
                     got_lat, bus.inst_o, h ? 0 : 5, model_word(32'h20));
        else n_pass++;
        model_done(32'h20);
    endtask

    task automatic test_wrap;
        logic [31:0] pcs [2];
        logic [31:0] exp_a;
        pcs[0] = 32'hFFFFFFFC;
        pcs[1] = 32'hFFFFFFFE;
        foreach (pcs[j]) begin
            run_fetch(pcs[j]);
            n_chk++;
            if (addr_q.size() !== 4)
                $display("FAIL wrap_nreads%0d: got %0d want 4",
                         j, addr_q.size());
            else n_pass++;
            for (int i = 0; i < addr_q.size() && i < 4; i++) begin
                exp_a = pcs[j] + 32'(i);
                n_chk++;
                if (addr_q[i] !== exp_a)
                    $display("FAIL wrap_addr%0d_%0d: got %h want %h",
                             j, i, addr_q[i], exp_a);
                else n_pass++;
            end
            n_chk++;
            if (bus.inst_pc_o !== pcs[j] || bus.inst_o !== model_word(pcs[j]))
                $display("FAIL wrap_word%0d: got %h@%h want %h@%h", j,
                         bus.inst_o, bus.inst_pc_o, model_word(pcs[j]), pcs[j]);
            else n_pass++;
            model_done(pcs[j]);
        end
    endtask

`ifdef ICACHE_EN
    task automatic test_cache;
        run_fetch(32'h10);
        model_done(32'h10);
        run_fetch(32'h10);
        n_chk++;
        if (got_lat !== 0 || addr_q.size() !== 0
            || bus.inst_o !== 32'h00100513)
            $display("FAIL cache_hit: got lat=%0d reads=%0d inst=%h want 0 0 00100513",
                     got_lat, addr_q.size(), bus.inst_o);
        else n_pass++;
        run_fetch(32'h110);
        model_done(32'h110);
        n_chk++;
        if (got_lat !== 5 || bus.inst_o !== model_word(32'h110))
            $display("FAIL cache_conflict: got lat=%0d inst=%h want 5 %h",
                     got_lat, bus.inst_o, model_word(32'h110));
        else n_pass++;
        run_fetch(32'h10);
        model_done(32'h10);
        n_chk++;
        if (got_lat !== 5 || bus.inst_o !== 32'h00100513)
            $display("FAIL cache_evicted: got lat=%0d inst=%h want 5 00100513",
                     got_lat, bus.inst_o);
        else n_pass++;
    endtask
`endif

    task automatic test_random;
        logic [31:0] pc;
        bit h;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) == 0)
                pc = 32'h10 + 32'($urandom_range(0, 3)) * 32'h100;
            else
                pc = $urandom;
            h = model_hit(pc);
            run_fetch(pc);
            n_chk++;
            if (bus.inst_o !== model_word(pc) || bus.inst_pc_o !== pc)
                $display("FAIL rand_word%0d: got %h@%h want %h@%h", i,
                         bus.inst_o, bus.inst_pc_o, model_word(pc), pc);
            else n_pass++;
            n_chk++;
            if (got_lat !== (h ? 0 : 5))
                $display("FAIL rand_lat%0d: got %0d want %0d",
                         i, got_lat, h ? 0 : 5);
            else n_pass++;
            model_done(pc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_wrap();
`ifdef ICACHE_EN
        test_cache();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
